// File: rtl/median3x3_stream_if.sv
// ---------------------------------------------------------------------------
// median3x3_stream_if
//
// Pixel stream bundle for the 3x3 median filter: one input stream and one
// output stream.
//
// Handshake rule (both streams): a beat transfers on a rising clock edge
// where valid && ready are both high. A producer must hold valid and its data
// and flags stable until the beat transfers. ready may change freely.
//
// Signals (DW = CH*PIX_W of the filter it connects to):
//   s_valid  source -> filter  input pixel valid
//   s_ready  filter -> source  filter can accept an input pixel
//   s_data   source -> filter  input pixel, channel k at [k*PIX_W +: PIX_W]
//   m_valid  filter -> sink    output pixel valid
//   m_ready  sink -> filter    sink accepts the output pixel
//   m_data   filter -> sink    filtered pixel, same channel packing
//   m_sof    filter -> sink    m_data is pixel (0,0) of a frame
//   m_eol    filter -> sink    m_data is the last pixel of a row
//
// Modports:
//   master : environment side (drives the input stream, sinks the output)
//   slave  : filter side
// ---------------------------------------------------------------------------
interface median3x3_stream_if #(
  parameter int DW = 24
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_sof;
  logic          m_eol;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_sof, m_eol
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_sof, m_eol
  );
endinterface

// File: rtl/median3x3_stream.sv
// ---------------------------------------------------------------------------
// median3x3_stream
//
// Streaming 3x3 median filter with clamp-to-edge borders. Pixels arrive in
// raster order, one per beat. Each channel is filtered on its own. The output
// is the 5th smallest of the 9 window values, using an unsigned compare.
// Two line buffers of IMG_W pixels hold the two previous rows.
//
// Parameters:
//   IMG_W  pixels per row (>= 2)
//   IMG_H  rows per frame (>= 2)
//   PIX_W  bits per channel component
//   CH     channels per pixel
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   bypass     (only with MEDIAN3X3_BYPASS_EN) output the window centre
//              instead of the median; sampled on each output load
//   io         median3x3_stream_if.slave; DW must equal CH*PIX_W
//   dbg_state  current FSM state (0 FILL, 1 RUN, 2 TAIL, 3 FLUSH)
//
// Optional feature macro: MEDIAN3X3_BYPASS_EN
//
// Operation:
//   FILL  : row 0 is written into both line buffers (row -1 == row 0).
//   RUN   : input (r,c) with c>=1 completes the window for output (r-1,c-1).
//   TAIL  : one extra output slot for (r-1,IMG_W-1), right column replicated.
//   FLUSH : row IMG_H-1 is emitted from the line buffers, bottom replicated.
// ---------------------------------------------------------------------------
module median3x3_stream #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = 8,
  parameter int CH    = 3
) (
  input  logic       CLK,
  input  logic       RST,
`ifdef MEDIAN3X3_BYPASS_EN
  input  logic       bypass,
`endif
  median3x3_stream_if.slave io,
  output logic [1:0] dbg_state
);

  localparam int DW = CH * PIX_W;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    TAIL  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Median-of-9 compare/exchange network (19 stages). After the last stage,
  // element 4 holds the median. Each pair (SA[k], SB[k]) is ordered so the
  // smaller value ends up at SA[k].
  localparam logic [3:0] SA [19] = '{4'd1, 4'd4, 4'd7, 4'd0, 4'd3, 4'd6, 4'd1,
                                     4'd4, 4'd7, 4'd0, 4'd5, 4'd4, 4'd3, 4'd1,
                                     4'd2, 4'd4, 4'd4, 4'd6, 4'd4};
  localparam logic [3:0] SB [19] = '{4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7, 4'd2,
                                     4'd5, 4'd8, 4'd3, 4'd8, 4'd7, 4'd6, 4'd4,
                                     4'd5, 4'd7, 4'd2, 4'd4, 4'd2};

  function automatic logic [PIX_W-1:0] med9(input logic [8:0][PIX_W-1:0] v_in);
    logic [8:0][PIX_W-1:0] p;
    logic [PIX_W-1:0]      t;
    p = v_in;
    for (int k = 0; k < 19; k++) begin
      if (p[SA[5'(k)]] > p[SB[5'(k)]]) begin
        t             = p[SA[5'(k)]];
        p[SA[5'(k)]]  = p[SB[5'(k)]];
        p[SB[5'(k)]]  = t;
      end
    end
    return p[4];
  endfunction

  // -------------------------------------------------------------------------
  // State and counters
  // -------------------------------------------------------------------------
  state_t        state, state_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // Output register
  logic          m_valid_q;
  logic [DW-1:0] m_data_q;
  logic          m_sof_q;
  logic          m_eol_q;

  // Control decoded from the state (FSM output process)
  logic          slot;       // output register may load this cycle
  logic          s_ready_c;
  logic          accept;     // input beat transfers this cycle
  logic          prod;       // a new result loads the output register
  logic          sof_nx;
  logic          eol_nx;
  logic [CW-1:0] rd_idx;     // line-buffer read column

  // Line buffers: lb_a holds row r-1, lb_b holds row r-2 (both clamped).
  logic [DW-1:0] lb_a [IMG_W];
  logic [DW-1:0] lb_b [IMG_W];

  // Window columns, index 0 = top row, 1 = middle, 2 = bottom.
  // c1 is the column left of the incoming one, c2 is two columns left.
  logic [2:0][DW-1:0] c1, c2, nc;
  logic [2:0][DW-1:0] w_l, w_c, w_r;

  logic [DW-1:0] med_data;
  logic [DW-1:0] res_data;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      FILL:  if (accept && col == COL_LAST) state_nx = RUN;
      RUN:   if (accept && col == COL_LAST) state_nx = TAIL;
      TAIL:  if (slot) state_nx = (row == ROW_LAST) ? FLUSH : RUN;
      FLUSH: if (slot && col == COL_LAST) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    slot      = !m_valid_q || io.m_ready;
    s_ready_c = (state == FILL || state == RUN) && slot;
    accept    = io.s_valid && s_ready_c;
    prod      = 1'b0;
    sof_nx    = 1'b0;
    eol_nx    = 1'b0;
    rd_idx    = col;
    case (state)
      RUN: begin
        prod   = accept && (col != '0);
        sof_nx = (row == RW'(1)) && (col == CW'(1));
      end
      TAIL: begin
        prod   = slot;
        eol_nx = 1'b1;
      end
      FLUSH: begin
        prod   = slot;
        eol_nx = (col == COL_LAST);
        // Read one column ahead so the right neighbour of the centre is on
        // hand. The right border column is replicated.
        rd_idx = (col != COL_LAST) ? col + CW'(1) : col;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

  // -------------------------------------------------------------------------
  // Position counters. row advances in TAIL, so TAIL still sees the row
  // just finished. That row decides between RUN and FLUSH.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      col <= '0;
      row <= '0;
    end else begin
      case (state)
        FILL, RUN: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (state == FILL) row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        TAIL: begin
          if (slot && row != ROW_LAST) row <= row + RW'(1);
        end
        FLUSH: begin
          if (slot) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= '0;
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Line buffers. Row 0 goes into both buffers, so row -1 reads as row 0.
  // Later rows shift lb_a into lb_b column by column.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (accept) begin
      if (state == FILL) begin
        lb_a[col] <= io.s_data;
        lb_b[col] <= io.s_data;
      end else begin
        lb_b[col] <= lb_a[col];
        lb_a[col] <= io.s_data;
      end
    end
  end

  // Incoming window column. In FLUSH, and on the TAIL cycle that preloads
  // FLUSH, the bottom row is the replicated last row.
  always_comb begin
    nc[0] = lb_b[rd_idx];
    nc[1] = lb_a[rd_idx];
    nc[2] = (state == RUN) ? io.s_data : lb_a[rd_idx];
  end

  // Column shift registers. At column 0 both registers take the new column,
  // which gives left-edge replication.
  always_ff @(posedge CLK) begin
    if (state == RUN && accept) begin
      if (col == '0) begin
        c1 <= nc;
        c2 <= nc;
      end else begin
        c2 <= c1;
        c1 <= nc;
      end
    end else if (state == TAIL && slot && row == ROW_LAST) begin
      c1 <= nc;
      c2 <= nc;
    end else if (state == FLUSH && slot) begin
      c2 <= c1;
      c1 <= nc;
    end
  end

  // In TAIL the centre is the last column, so the right column repeats it.
  always_comb begin
    w_l = c2;
    w_c = c1;
    w_r = (state == TAIL) ? c1 : nc;
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [8:0][PIX_W-1:0] v;
    assign v = {w_l[0][g*PIX_W +: PIX_W], w_l[1][g*PIX_W +: PIX_W], w_l[2][g*PIX_W +: PIX_W],
                w_c[0][g*PIX_W +: PIX_W], w_c[1][g*PIX_W +: PIX_W], w_c[2][g*PIX_W +: PIX_W],
                w_r[0][g*PIX_W +: PIX_W], w_r[1][g*PIX_W +: PIX_W], w_r[2][g*PIX_W +: PIX_W]};
    assign med_data[g*PIX_W +: PIX_W] = med9(v);
  end

`ifdef MEDIAN3X3_BYPASS_EN
  assign res_data = bypass ? w_c[1] : med_data;
`else
  assign res_data = med_data;
`endif

  // -------------------------------------------------------------------------
  // Output register. It loads only when empty or being drained. m_valid
  // falls when a drained slot gets no new result.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
    end else if (slot) begin
      m_valid_q <= prod;
      if (prod) begin
        m_data_q <= res_data;
        m_sof_q  <= sof_nx;
        m_eol_q  <= eol_nx;
      end
    end
  end

  assign io.s_ready = s_ready_c;
  assign io.m_valid = m_valid_q;
  assign io.m_data  = m_data_q;
  assign io.m_sof   = m_sof_q;
  assign io.m_eol   = m_eol_q;

endmodule

// File: tb/tb_median3x3_stream.sv
// ---------------------------------------------------------------------------
// tb_median3x3_stream
//
// Directed and random frames through a 5x4, 3-channel filter. The reference
// model computes every output pixel straight from the frame image: it
// gathers the 9 clamped neighbours, sorts them and takes the middle one.
// ---------------------------------------------------------------------------
module tb_median3x3_stream;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int PIX_W = 8;
  localparam int CH    = 3;
  localparam int DW    = CH * PIX_W;
  localparam int QW    = DW + 2;   // {sof, eol, data}
  localparam int NPIX  = IMG_W * IMG_H;

  // Clock and reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  median3x3_stream_if #(.DW(DW)) sif ();

  median3x3_stream #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .CH(CH)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .io        (sif),
    .dbg_state (dbg_state)
  );

  // Scoreboard
  int              n_cmp = 0;
  int              n_bad = 0;
  logic [DW-1:0]   img [IMG_H][IMG_W];
  logic [QW-1:0]   exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model
  function automatic logic [PIX_W-1:0] ref_med(input int r, input int c, input int k);
    int q [$];
    int rr, cc;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (rr < 0) rr = 0;
        if (rr > IMG_H - 1) rr = IMG_H - 1;
        if (cc < 0) cc = 0;
        if (cc > IMG_W - 1) cc = IMG_W - 1;
        q.push_back(int'(img[rr][cc][k*PIX_W +: PIX_W]));
      end
    end
    q.sort();
    return PIX_W'(q[4]);
  endfunction

  // mode 0 constant, 1 impulse, 2 left column, 3 channel ramps, other random
  task automatic load_frame(input int mode, input bit push);
    logic [DW-1:0] d;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        for (int k = 0; k < CH; k++) begin
          case (mode)
            0:       img[r][c][k*PIX_W +: PIX_W] = 8'h5A;
            1:       img[r][c][k*PIX_W +: PIX_W] = (r == 1 && c == 1) ? 8'hFF : 8'h00;
            2:       img[r][c][k*PIX_W +: PIX_W] = (c == 0) ? 8'hC8 : 8'h00;
            3:       img[r][c][k*PIX_W +: PIX_W] = (k == 0) ? PIX_W'(r * 10) :
                                                   (k == 1) ? PIX_W'(c * 10) : 8'h33;
            default: img[r][c][k*PIX_W +: PIX_W] = PIX_W'($urandom_range(255));
          endcase
        end
      end
    end
    if (push) begin
      for (int r = 0; r < IMG_H; r++) begin
        for (int c = 0; c < IMG_W; c++) begin
          for (int k = 0; k < CH; k++) d[k*PIX_W +: PIX_W] = ref_med(r, c, k);
          exp_q.push_back({(r == 0 && c == 0), (c == IMG_W - 1), d});
        end
      end
    end
  endtask

  // Source driver: presents pixels in raster order, holding each until taken.
  task automatic drive_frame(input int n_pix, input int gap_pct);
    int   idx = 0;
    int   budget = 0;
    logic pend = 1'b0;
    while (idx < n_pix && budget < 5000) begin
      @(posedge clk); #1;
      if (!pend) begin
        sif.s_valid = ($urandom_range(99) >= gap_pct);
        sif.s_data  = img[idx / IMG_W][idx % IMG_W];
      end
      @(negedge clk);
      if (sif.s_valid && sif.s_ready) begin
        idx++;
        pend = 1'b0;
      end else begin
        pend = sif.s_valid;
      end
      budget++;
    end
    @(posedge clk); #1;
    sif.s_valid = 1'b0;
    if (idx < n_pix) check("src_timeout", 64'(idx), 64'(n_pix));
  endtask

  // Sink: random m_ready, checks every accepted beat and stall stability.
  task automatic sink_frame(input int n_out, input int ready_pct, output int low_cnt);
    int            got = 0;
    int            budget = 0;
    logic          held_v = 1'b0;
    logic [QW-1:0] held = '0;
    logic [QW-1:0] obs;
    low_cnt = 0;
    while (got < n_out && budget < 5000) begin
      @(posedge clk); #1;
      sif.m_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (!sif.s_ready) low_cnt++;
      obs = {sif.m_sof, sif.m_eol, sif.m_data};
      if (held_v) begin
        check("stall_valid", 64'(sif.m_valid), 64'(1));
        check("stall_hold", 64'(obs), 64'(held));
      end
      if (sif.m_valid && sif.m_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 64'(obs), 64'(0));
        else check("pixel", 64'(obs), 64'(exp_q.pop_front()));
        got++;
        held_v = 1'b0;
      end else begin
        held_v = sif.m_valid;
        held   = obs;
      end
      budget++;
    end
    if (got < n_out) check("sink_timeout", 64'(got), 64'(n_out));
  endtask

  task automatic run_frame(input int gap_pct, input int ready_pct, output int low_cnt);
    int lc;
    fork
      drive_frame(NPIX, gap_pct);
      sink_frame(NPIX, ready_pct, lc);
    join
    low_cnt = lc;
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin
    int low;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.m_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(sif.m_valid), 64'(0));
    check("rst_m_sof",   64'(sif.m_sof),   64'(0));
    check("rst_m_eol",   64'(sif.m_eol),   64'(0));
    check("rst_m_data",  64'(sif.m_data),  64'(0));
    check("rst_state",   64'(dbg_state),   64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_s_ready", 64'(sif.s_ready), 64'(1));

    // Constant frame, free-running: s_ready low once per TAIL and for FLUSH
    load_frame(0, 1'b1);
    run_frame(0, 100, low);
    check("tail_flush_low_cycles", 64'(low), 64'((IMG_H - 1) + IMG_W));

    // Impulse, left-edge column, channel ramps
    load_frame(1, 1'b1);
    run_frame(0, 100, low);
    load_frame(2, 1'b1);
    run_frame(30, 100, low);
    load_frame(3, 1'b1);
    run_frame(20, 70, low);

    // Random frames under backpressure, back to back
    for (int f = 0; f < 6; f++) begin
      load_frame(4, 1'b1);
      run_frame(30, 50, low);
    end
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("idle_in_fill", 64'(dbg_state), 64'(0));

    // Reset mid-frame, right after input (2,3) is accepted
    load_frame(4, 1'b0);
    sif.m_ready = 1'b1;
    drive_frame(2 * IMG_W + 4, 0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_m_valid", 64'(sif.m_valid), 64'(0));
    check("midrst_m_sof",   64'(sif.m_sof),   64'(0));
    check("midrst_m_data",  64'(sif.m_data),  64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_state",   64'(dbg_state),   64'(0));
    check("midrst_s_ready", 64'(sif.s_ready), 64'(1));

    // Next frame starts cleanly with sof on (0,0)
    load_frame(4, 1'b1);
    run_frame(10, 60, low);
    check("queue_drained_end", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
